// File: rtl/key_event_uart_tx.sv
// key_event_uart_tx: synchronizes keyboard event strobes, queues the codes in a
// 16-entry FIFO and serializes them as UART 8N1 frames.
module key_event_uart_tx #(
    parameter int CLK_DIV = 417,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               keyEventReady,
    input  logic [7:0]         keyEvent,
    input  logic               ovfClr,
    output logic               txLine,
    output logic               busy,
    output logic [FIFO_AW:0]   fifoCount,
    output logic               overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, nextState;
    logic [2:0] syncQ;
    logic [7:0] key1, key2;
    logic [7:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr, rdPtr;
    logic [7:0] shiftReg;
    logic [2:0] bitCnt;
    logic [CW-1:0] baudCnt;
    logic detect, full, pop, push, drop, baudDone;

    assign detect = syncQ[1] & ~syncQ[2];
    assign full = fifoCount == (FIFO_AW+1)'(DEPTH);
    assign pop = state == IDLE && fifoCount != '0;
    // a pop frees a slot in the same cycle, so a full FIFO still accepts then
    assign push = detect && (!full || pop);
    assign drop = detect && full && !pop;
    assign baudDone = baudCnt == CW'(CLK_DIV - 1);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  nextState = pop ? START : IDLE;
            START: nextState = baudDone ? DATA : START;
            DATA:  nextState = baudDone && bitCnt == 3'd7 ? STOP : DATA;
            STOP:  nextState = baudDone ? IDLE : STOP;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nextState;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ <= '0;
            key1 <= '0;
            key2 <= '0;
        end else begin
            syncQ <= {syncQ[1:0], keyEventReady};
            key1 <= keyEvent;
            key2 <= key1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= key2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            fifoCount <= '0;
            overflow <= 1'b0;
        end else begin
            wrPtr <= wrPtr + FIFO_AW'(push);
            rdPtr <= rdPtr + FIFO_AW'(pop);
            fifoCount <= fifoCount + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            overflow <= drop | (overflow & ~ovfClr);
        end
    end

    // line outputs are registered from the state, trailing it by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baudCnt <= '0;
            bitCnt <= '0;
            shiftReg <= '0;
            txLine <= 1'b1;
            busy <= 1'b0;
        end else begin
            baudCnt <= state == IDLE || baudDone ? '0 : baudCnt + CW'(1);
            bitCnt <= state != DATA ? 3'd0 : baudDone ? bitCnt + 3'd1 : bitCnt;
            shiftReg <= pop ? mem[rdPtr] : shiftReg;
            txLine <= state == START ? 1'b0 : state == DATA ? shiftReg[bitCnt] : 1'b1;
            busy <= state != IDLE;
        end
    end
endmodule
